// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS main controller.
// Holds the FSM state codes, opcode/funct constants, the datapath select
// encodings (npc_sel, reg_dst, wd_sel, ext_op, alu_op) and the
// instruction-class enum produced by mc_decode.
package mc_pkg;

    // FSM states; the numeric values are visible on the debug port.
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXE    = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Function codes (IR[5:0]) for R-type
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // Next-PC source
    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;
    localparam logic [1:0] NPC_REG  = 2'd3;

    // GRF write register
    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // GRF write data
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DMR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_ADDU = 4'd1,
        CL_SUBU = 4'd2,
        CL_JR   = 4'd3,
        CL_ORI  = 4'd4,
        CL_LUI  = 4'd5,
        CL_LW   = 4'd6,
        CL_SW   = 4'd7,
        CL_BEQ  = 4'd8,
        CL_J    = 4'd9,
        CL_JAL  = 4'd10
    } instr_class_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational op/funct -> instruction class classifier.
// Ports:
//   op_i    [5:0]  IR[31:26]
//   funct_i [5:0]  IR[5:0]
//   cls_o   [3:0]  instr_class_e value; anything unrecognised is CL_NOP
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] cls_o
);

    instr_class_e cls;

    always_comb begin
        cls = CL_NOP;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: cls = CL_ADDU;
                    FN_SUBU: cls = CL_SUBU;
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_NOP;  // includes sll-as-nop
                endcase
            end
            OP_ORI:  cls = CL_ORI;
            OP_LUI:  cls = CL_LUI;
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            OP_BEQ:  cls = CL_BEQ;
            OP_J:    cls = CL_J;
            OP_JAL:  cls = CL_JAL;
            default: cls = CL_NOP;
        endcase
    end

    assign cls_o = cls;

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: main controller of the multi-cycle MIPS core. A five-state FSM
// (FETCH, DECODE, EXE, MEM, WB) sequences the shared datapath one phase per
// cycle; all outputs are combinational from state, op, funct (and zero for
// the beq PC write).
// Ports:
//   clk, reset (sync, active-high), op/funct (from IR), zero (ALU result==0)
//   pc_wr, ir_wr, reg_wr, mem_wr : write enables
//   npc_sel, reg_dst, wd_sel, alu_src_b, ext_op, alu_op : datapath selects
//   instr_done : last cycle of each instruction
//   state      : current FSM state (debug)
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic [1:0] npc_sel,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src_b,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       mem_wr,
    output logic       instr_done,
    output logic [2:0] state
);

    logic [2:0]   state_q, state_d;
    logic [3:0]   cls_raw;
    instr_class_e cls;

    mc_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .cls_o   (cls_raw)
    );

    assign cls   = instr_class_e'(cls_raw);
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Every output defaults to 0; reset leaves all of them at 0 so an
    // aborted instruction cannot commit anything in the reset cycle.
    always_comb begin
        state_d    = ST_FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        npc_sel    = NPC_PC4;
        reg_wr     = 1'b0;
        reg_dst    = RD_RT;
        wd_sel     = WD_ALU;
        alu_src_b  = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        mem_wr     = 1'b0;
        instr_done = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    state_d = ST_EXE;
                    case (cls)
                        CL_J: begin
                            pc_wr = 1'b1; npc_sel = NPC_JUMP;
                            instr_done = 1'b1; state_d = ST_FETCH;
                        end
                        CL_JAL: begin
                            pc_wr = 1'b1; npc_sel = NPC_JUMP;
                            reg_wr = 1'b1; reg_dst = RD_RA; wd_sel = WD_PC;
                            instr_done = 1'b1; state_d = ST_FETCH;
                        end
                        CL_JR: begin
                            pc_wr = 1'b1; npc_sel = NPC_REG;
                            instr_done = 1'b1; state_d = ST_FETCH;
                        end
                        CL_NOP: begin
                            instr_done = 1'b1; state_d = ST_FETCH;
                        end
                        default: state_d = ST_EXE;
                    endcase
                end
                ST_EXE: begin
                    state_d = ST_WB;
                    case (cls)
                        CL_ADDU: alu_op = ALU_ADD;
                        CL_SUBU: alu_op = ALU_SUB;
                        CL_ORI: begin
                            alu_src_b = 1'b1; ext_op = EXT_ZERO; alu_op = ALU_OR;
                        end
                        CL_LUI: begin
                            alu_src_b = 1'b1; ext_op = EXT_LUI; alu_op = ALU_OR;
                        end
                        CL_LW, CL_SW: begin
                            alu_src_b = 1'b1; ext_op = EXT_SIGN; alu_op = ALU_ADD;
                            state_d = ST_MEM;
                        end
                        CL_BEQ: begin
                            alu_op = ALU_SUB;
                            // zero settles within this cycle; the PC load
                            // follows it combinationally.
                            pc_wr = zero; npc_sel = NPC_BR;
                            instr_done = 1'b1; state_d = ST_FETCH;
                        end
                        default: state_d = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    state_d = ST_FETCH;
                    if (cls == CL_SW) begin
                        mem_wr = 1'b1; instr_done = 1'b1;
                    end else if (cls == CL_LW) begin
                        // DM read is latched into the datapath read register.
                        state_d = ST_WB;
                    end
                end
                ST_WB: begin
                    reg_wr = 1'b1; instr_done = 1'b1; state_d = ST_FETCH;
                    if (cls == CL_ADDU || cls == CL_SUBU) begin
                        reg_dst = RD_RD; wd_sel = WD_ALU;
                    end else if (cls == CL_LW) begin
                        reg_dst = RD_RT; wd_sel = WD_DMR;
                    end else begin
                        reg_dst = RD_RT; wd_sel = WD_ALU;
                    end
                end
                // Illegal encodings: no enables, back to FETCH.
                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected output records built from
// the class/phase table, compared every cycle on the falling edge.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset, zero;
    logic [5:0] op, funct;
    logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src_b, instr_done;
    logic [1:0] npc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0] alu_op, state;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .alu_op(alu_op), .mem_wr(mem_wr),
        .instr_done(instr_done), .state(state)
    );

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic [1:0] npc_sel;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src_b;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
        logic       mem_wr;
        logic       instr_done;
        logic [2:0] state;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   last_cpi = 0;

    localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4,
                   K_LUI = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

    function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
                if (f == 6'b100001) return K_ADDU;
                if (f == 6'b100011) return K_SUBU;
                if (f == 6'b001000) return K_JR;
                return K_NOP;
            end
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_NOP;
        endcase
    endfunction

    function automatic int n_cyc(input int c);
        if (c == K_J || c == K_JAL || c == K_JR || c == K_NOP) return 2;
        if (c == K_BEQ) return 3;
        if (c == K_LW) return 5;
        return 4;
    endfunction

    // Expected outputs for cycle k (0-based) of an instruction of class c.
    function automatic out_t phase_out(input int c, input int k, input logic z);
        out_t r;
        r = '0;
        if (k == 0) begin
            r.state = 3'd0; r.ir_wr = 1'b1; r.pc_wr = 1'b1;
        end else if (k == 1) begin
            r.state = 3'd1;
            if (c == K_J)   begin r.pc_wr = 1; r.npc_sel = 2; r.instr_done = 1; end
            if (c == K_JAL) begin r.pc_wr = 1; r.npc_sel = 2; r.reg_wr = 1;
                                  r.reg_dst = 2; r.wd_sel = 2; r.instr_done = 1; end
            if (c == K_JR)  begin r.pc_wr = 1; r.npc_sel = 3; r.instr_done = 1; end
            if (c == K_NOP) r.instr_done = 1;
        end else if (k == 2) begin
            r.state = 3'd2;
            if (c == K_SUBU) r.alu_op = 1;
            if (c == K_ORI) begin r.alu_src_b = 1; r.ext_op = 0; r.alu_op = 2; end
            if (c == K_LUI) begin r.alu_src_b = 1; r.ext_op = 2; r.alu_op = 2; end
            if (c == K_LW || c == K_SW) begin r.alu_src_b = 1; r.ext_op = 1; end
            if (c == K_BEQ) begin r.alu_op = 1; r.pc_wr = z; r.npc_sel = 1; r.instr_done = 1; end
        end else if (k == 3 && (c == K_SW || c == K_LW)) begin
            r.state = 3'd3;
            if (c == K_SW) begin r.mem_wr = 1; r.instr_done = 1; end
        end else begin
            r.state = 3'd4; r.reg_wr = 1; r.instr_done = 1;
            if (c == K_ADDU || c == K_SUBU) r.reg_dst = 1;
            if (c == K_LW) r.wd_sel = 1;
        end
        return r;
    endfunction

    function automatic out_t dut_out();
        out_t r;
        r = {pc_wr, ir_wr, npc_sel, reg_wr, reg_dst, wd_sel, alu_src_b,
             ext_op, alu_op, mem_wr, instr_done, state};
        return r;
    endfunction

    // Compare process: one expected record per cycle, checked mid-cycle.
    always @(negedge clk) begin
        out_t got, exp;
        if (exp_q.size() > 0) begin
            got = dut_out();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t op=%b funct=%b got=%h exp=%h",
                         $time, op, funct, got, exp);
            end
        end
        if (reset) cyc_cnt = 0;
        else begin
            cyc_cnt++;
            if (instr_done) begin
                last_cpi = cyc_cnt;
                cyc_cnt  = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH. abort_at >= 0 pulses reset in
    // that cycle of the instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int abort_at);
        int   c, n;
        out_t r;
        c = cls_of(o, f);
        n = n_cyc(c);
        op = o; funct = f; zero = z;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                r = '0;
                r.state = phase_out(c, k, z).state;
                exp_q.push_back(r);
                reset = 1'b1;
                next_cycle();
                reset = 1'b0;
                return;
            end
            exp_q.push_back(phase_out(c, k, z));
            next_cycle();
        end
    endtask

    task automatic check_cpi(input int exp_cpi, input string name);
        checks++;
        if (last_cpi != exp_cpi) begin
            errors++;
            $display("FAIL cpi_%s got=%0d exp=%0d", name, last_cpi, exp_cpi);
        end
    endtask

    initial begin
        int sel, ab;
        logic [5:0] ro, rf;
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        next_cycle();
        // Three reset cycles: everything 0, state FETCH.
        repeat (3) begin
            exp_q.push_back('0);
            next_cycle();
        end
        reset = 1'b0;

        run_instr(6'b000000, 6'b100001, 1'b0, -1); check_cpi(4, "addu");
        run_instr(6'b000000, 6'b100011, 1'b1, -1); check_cpi(4, "subu");
        run_instr(6'b100011, 6'b010101, 1'b0, -1); check_cpi(5, "lw");
        run_instr(6'b101011, 6'b000000, 1'b1, -1); check_cpi(4, "sw");
        run_instr(6'b000100, 6'b000000, 1'b1, -1); check_cpi(3, "beq_taken");
        run_instr(6'b000100, 6'b111111, 1'b0, -1); check_cpi(3, "beq_not_taken");
        run_instr(6'b000011, 6'b000000, 1'b0, -1); check_cpi(2, "jal");
        run_instr(6'b000000, 6'b001000, 1'b0, -1); check_cpi(2, "jr");
        run_instr(6'b111111, 6'b101010, 1'b1, -1); check_cpi(2, "illegal_op");
        run_instr(6'b001101, 6'b000000, 1'b0, -1); check_cpi(4, "ori");
        run_instr(6'b001111, 6'b000000, 1'b1, -1); check_cpi(4, "lui");
        run_instr(6'b000010, 6'b000000, 1'b0, -1); check_cpi(2, "j");
        run_instr(6'b000000, 6'b000000, 1'b0, -1); check_cpi(2, "sll_nop");
        // Reset pulse in MEM of sw, then a normal instruction from FETCH.
        run_instr(6'b101011, 6'b000000, 1'b0, 3);
        run_instr(6'b000000, 6'b100001, 1'b0, -1); check_cpi(4, "addu_after_abort");

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 11);
            rf  = 6'($urandom_range(0, 63));
            case (sel)
                0:  begin ro = 6'b000000; rf = 6'b100001; end
                1:  begin ro = 6'b000000; rf = 6'b100011; end
                2:  begin ro = 6'b000000; rf = 6'b001000; end
                3:  ro = 6'b001101;
                4:  ro = 6'b001111;
                5:  ro = 6'b100011;
                6:  ro = 6'b101011;
                7:  ro = 6'b000100;
                8:  ro = 6'b000010;
                9:  ro = 6'b000011;
                10: ro = 6'b000000;
                default: ro = 6'($urandom_range(0, 63));
            endcase
            ab = -1;
            if ($urandom_range(0, 7) == 0)
                ab = $urandom_range(0, n_cyc(cls_of(ro, rf)) - 1);
            run_instr(ro, rf, 1'($urandom_range(0, 1)), ab);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Main controller for the multi-cycle MIPS core: a five-state FSM that sequences the shared datapath (PC, IR, GRF, single ALU, DM) one phase per cycle. It decodes `op`/`funct` from the instruction register and drives every write enable and mux select, so one ALU and one memory port serve fetch, address, branch and arithmetic work. It sits beside the datapath inside `mips` and replaces the single-cycle combinational controller.

## Interface
Parameters: none; encodings are fixed in `mc_pkg`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26]; stable from the end of FETCH.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU result == 0, combinational from the datapath.
- `pc_wr` out 1: PC load enable.
- `ir_wr` out 1: IR load enable.
- `npc_sel` out 2: next PC source.
  - 0 = PC+4.
  - 1 = branch target, computed as PC + (sext(imm)<<2), using the already-incremented PC.
  - 2 = {PC[31:28], instr_index, 2'b00}.
  - 3 = GRF[rs].
- `reg_wr` out 1: GRF write enable.
- `reg_dst` out 2: write register. 0 = rt, 1 = rd, 2 = $31.
- `wd_sel` out 2: write data. 0 = ALUOut, 1 = DM read register, 2 = PC register (instruction address + 4).
- `alu_src_b` out 1: ALU operand B. 0 = GRF[rt], 1 = extended immediate.
- `ext_op` out 2: immediate extension. 0 = zero, 1 = sign, 2 = imm<<16.
- `alu_op` out 3: 0 = add, 1 = sub, 2 = or.
- `mem_wr` out 1: DM write enable.
- `instr_done` out 1: high in the last cycle of every instruction.
- `state` out 3: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. The state register is the only storage in the block. Outputs are combinational from state, op and funct. `pc_wr` in EXE also depends on `zero`.
- Instruction classes: addu (000000/100001), subu (000000/100011), jr (000000/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011. Every other op/funct, including sll-nop, is class NOP.
- FETCH: `ir_wr`=1, `pc_wr`=1, `npc_sel`=0. Next state is DECODE.
- DECODE: behaviour by class.
  - j: `pc_wr`=1, `npc_sel`=2.
  - jal: as j, plus `reg_wr`=1, `reg_dst`=2, `wd_sel`=2.
  - jr: `pc_wr`=1, `npc_sel`=3.
  - NOP: no enables.
  - j, jal, jr and NOP assert `instr_done` and go to FETCH. All other classes go to EXE.
- EXE: behaviour by class.
  - R-type: `alu_src_b`=0; `alu_op` is 0 for addu, 1 for subu.
  - ori: `alu_src_b`=1, `ext_op`=0, `alu_op`=2.
  - lui: `alu_src_b`=1, `ext_op`=2, `alu_op`=2. The datapath forces operand A to 0 for lui.
  - lw/sw: `ext_op`=1, `alu_op`=0, `alu_src_b`=1.
  - beq: `alu_op`=1, `alu_src_b`=0, `pc_wr`=`zero`, `npc_sel`=1, `instr_done`=1; next state FETCH.
  - R-type, ori and lui go to WB. lw and sw go to MEM.
- MEM:
  - sw: `mem_wr`=1, `instr_done`=1; next state FETCH.
  - lw: DM read is latched into the read register; next state WB.
- WB: `reg_wr`=1, `instr_done`=1; next state FETCH.
  - R-type: `reg_dst`=1, `wd_sel`=0.
  - ori/lui: `reg_dst`=0, `wd_sel`=0.
  - lw: `reg_dst`=0, `wd_sel`=1.
- Deasserted selects drive 0. Write enables are high only in the states listed above.

## Timing
- Cycles per instruction: j/jal/jr/NOP 2; beq 3; addu/subu/ori/lui/sw 4; lw 5.
- While `reset`=1:
  - `state` is forced to FETCH on each edge.
  - All enables (`pc_wr`, `ir_wr`, `reg_wr`, `mem_wr`) and `instr_done` are forced to 0 combinationally.
  - All selects are 0.
- The first edge with `reset`=0 performs the fetch. The reset PC (0x00003000) is owned by the datapath.
- Reset asserted in any state aborts the instruction with no further writes. Writes already committed in earlier cycles stand.
- In EXE for beq, `zero` must settle within the same cycle; `pc_wr` follows it combinationally.
- `op`/`funct` are sampled only in DECODE, EXE, MEM and WB. Their values during FETCH are don't-care.
- Illegal state encodings (5–7) go to FETCH on the next edge with no enables asserted.

## Structure
- `mc_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - `npc_sel`, `reg_dst`, `wd_sel`, `ext_op` and `alu_op` encodings;
  - the instruction-class enum.
- Sub-module `mc_decode` is a combinational op/funct → class classifier. `mc_ctrl` holds the state register and the output decode.

## Test plan
- Reset held 3 cycles, then released:
  - During reset: all enables 0, `state`=0.
  - First cycle after release: `ir_wr`=`pc_wr`=1.
- op=000000, funct=100001 (addu): state sequence 0→1→2→4→0.
  - WB: `reg_wr`=1, `reg_dst`=1, `wd_sel`=0.
  - `instr_done` high only in WB.
- lw (100011), then sw (101011):
  - lw: 5 cycles; WB has `wd_sel`=1, `reg_dst`=0.
  - sw: 4 cycles; MEM has `mem_wr`=1; `reg_wr` never 1.
- beq (000100) in EXE:
  - `zero`=1 → `pc_wr`=1, `npc_sel`=1.
  - `zero`=0 → `pc_wr`=0.
  - Both cases: next state FETCH, 3 cycles.
- jal (000011) in DECODE: `pc_wr`=1, `npc_sel`=2, `reg_wr`=1, `reg_dst`=2, `wd_sel`=2; 2 cycles. jr: `npc_sel`=3. op=111111: no enables, 2 cycles.
- `reset` pulsed for 1 cycle while in MEM of an sw: `mem_wr`=0 in that cycle, next state FETCH.
